fetch_hazard_ctrl: RTL and testbench

//  Sequences the fetch-stage PC register and the IF/ID, ID/EX pipeline registers of the 5-stage core.

---
 rtl/fetch_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_hazard_ctrl.sv
// Fetch/hazard sequencer: PC enable, IF/ID stall/flush, ID/EX flush, boot hold, stale-fetch discard.
// Outputs are combinational from state and inputs; optional perf counters under `HAZ_PERF_EN`.
`timescale 1ns/1ps
module fetch_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    output logic             PCEnF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [1:0] S_BOOT      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_IMEM_WAIT = 2'd2;
    localparam logic [1:0] S_DISCARD   = 2'd3;

    localparam logic [7:0] BOOT_INIT = 8'(BOOT_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_boot_cnt;
    logic [1:0] w_state_nxt;
    logic       w_lw_stall;
    logic       w_pcsrc_taken;

    assign w_lw_stall = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= BOOT_INIT;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_BOOT) && (r_boot_cnt != 8'd0)) begin
                r_boot_cnt <= r_boot_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        PCEnF         = 1'b0;
        StallD        = 1'b0;
        FlushD        = 1'b1;
        FlushE        = 1'b1;
        w_pcsrc_taken = 1'b0;
        w_state_nxt   = r_state;
        case (r_state)
            S_BOOT: begin
                if (r_boot_cnt == 8'd0) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN, S_IMEM_WAIT: begin
                imem_req = 1'b1;
                FlushD   = 1'b0;
                FlushE   = 1'b0;
                if (PCSrcE) begin
                    PCEnF         = 1'b1;
                    FlushD        = 1'b1;
                    FlushE        = 1'b1;
                    w_pcsrc_taken = 1'b1;
                end else if (w_lw_stall) begin
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (!imem_ready) begin
                    FlushD = 1'b1;
                end else begin
                    PCEnF = 1'b1;
                end
                if (imem_ready) begin
                    w_state_nxt = S_RUN;
                end else if (PCSrcE) begin
                    w_state_nxt = S_DISCARD;
                end else begin
                    w_state_nxt = S_IMEM_WAIT;
                end
            end
            S_DISCARD: begin
                // The in-flight response belongs to the old path; keep IF/ID flushed until it lands.
                FlushE = 1'b0;
                if (PCSrcE) begin
                    PCEnF         = 1'b1;
                    FlushE        = 1'b1;
                    w_pcsrc_taken = 1'b1;
                end
                // No new request is issued here, so the arriving response must end the wait.
                w_state_nxt = imem_ready ? S_RUN : S_DISCARD;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;

    assign w_stall_evt = (r_state != S_BOOT) & ~PCEnF;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_pcsrc_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: vector table, hand-written corner sequences, random run vs reference model.
`timescale 1ns/1ps
module tb_fetch_hazard_ctrl;

    localparam int BOOT = 2;
    localparam int CW   = 16;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       imem_ready = 1'b1;
    logic       LoadE = 1'b0;
    logic       PCSrcE = 1'b0;
    logic [4:0] Rs1D = '0;
    logic [4:0] Rs2D = '0;
    logic [4:0] RdE = '0;
    logic       imem_req, PCEnF, StallD, FlushD, FlushE;
`ifdef HAZ_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    fetch_hazard_ctrl #(.BOOT_CYCLES(BOOT), .REG_W(5), .CNT_W(CW)) dut (
        .CLK(CLK), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .PCEnF(PCEnF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZ_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Output bundle: {PCEnF, StallD, FlushD, FlushE, imem_req}
    wire logic [4:0] w_out = {PCEnF, StallD, FlushD, FlushE, imem_req};

    localparam logic [4:0] O_BOOT   = 5'b00110;
    localparam logic [4:0] O_NORM   = 5'b10001;
    localparam logic [4:0] O_BR     = 5'b10111;
    localparam logic [4:0] O_LW     = 5'b01011;
    localparam logic [4:0] O_MISS   = 5'b00101;
    localparam logic [4:0] O_DISC   = 5'b00100;
    localparam logic [4:0] O_DISCBR = 5'b10110;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: remaining boot cycles, and whether a stale fetch is still in flight.
    bit m_reset = 1'b1;
    int m_boot_left = BOOT;
    bit m_discard = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [4:0] model_out();
        bit hit;
        hit = LoadE && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
        if (m_reset || m_boot_left > 0) return O_BOOT;
        if (m_discard) return PCSrcE ? O_DISCBR : O_DISC;
        if (PCSrcE) return O_BR;
        if (hit) return O_LW;
        if (!imem_ready) return O_MISS;
        return O_NORM;
    endfunction

    task automatic model_update();
        logic [4:0] o;
        if (m_reset) begin
            m_boot_left = BOOT;
            m_discard   = 1'b0;
            m_stall     = 0;
            m_flush     = 0;
        end else if (m_boot_left > 0) begin
            m_boot_left = m_boot_left - 1;
        end else begin
            o = model_out();
            if (!o[4] && m_stall < (1 << CW) - 1) m_stall = m_stall + 1;
            if (PCSrcE && m_flush < (1 << CW) - 1) m_flush = m_flush + 1;
            m_discard = m_discard ? !imem_ready : (!imem_ready && PCSrcE);
        end
    endtask

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm);
`ifdef HAZ_PERF_EN
        n_checks++;
        if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
            n_err++;
            $display("FAIL %s stall_cnt=%0d want=%0d flush_cnt=%0d want=%0d",
                     nm, stall_cnt, m_stall, flush_cnt, m_flush);
        end
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic drive(input logic pc, input logic rdy, input logic ld,
                         input logic [4:0] rde, input logic [4:0] rs1, input logic [4:0] rs2);
        PCSrcE = pc; imem_ready = rdy; LoadE = ld; RdE = rde; Rs1D = rs1; Rs2D = rs2;
    endtask

    task automatic tick();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc(input logic pc, input logic rdy, input logic ld,
                       input logic [4:0] rde, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] exp, input string nm);
        drive(pc, rdy, ld, rde, rs1, rs2);
        #1;
        chk(nm, w_out, exp);
        chk({nm, "_model"}, w_out, model_out());
        tick();
    endtask

    typedef struct {
        logic       pc;
        logic       rdy;
        logic       ld;
        logic [4:0] rde;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, O_NORM};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 5'd5, 5'd1, 5'd5, O_LW};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, O_NORM};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd2, O_LW};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, O_NORM};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd5, O_BR};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, O_MISS};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, O_LW};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_BR};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 5'd6, O_NORM};

        // Reset state
        #1;
        chk("reset_out", w_out, O_BOOT);
        chk_cnt("reset_cnt");
        repeat (2) tick();
        reset = 1'b0; m_reset = 1'b0;

        // Boot window: PCSrcE must not move the PC
        cyc(1, 1, 0, 0, 0, 0, O_BOOT, "boot0");
        cyc(1, 1, 0, 0, 0, 0, O_BOOT, "boot1");
        cyc(0, 1, 0, 0, 0, 0, O_NORM, "run0");

        // Vector table, each applied from RUN
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            tick();
            drive(vecs[i].pc, vecs[i].rdy, vecs[i].ld, vecs[i].rde, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk($sformatf("vec%0d", i), w_out, vecs[i].exp);
            tick();
        end
        drive(0, 1, 0, 0, 0, 0);
        tick();

        // Slow imem: three wait cycles then back to RUN
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, O_MISS, $sformatf("miss%0d", i));
        cyc(0, 1, 0, 0, 0, 0, O_NORM, "miss_done");
        cyc(0, 1, 0, 0, 0, 0, O_NORM, "miss_run");

        // Redirect during a wait: stale response is discarded
        cyc(0, 0, 0, 0, 0, 0, O_MISS,   "wait");
        cyc(1, 0, 0, 0, 0, 0, O_BR,     "wait_br");
        cyc(0, 0, 0, 0, 0, 0, O_DISC,   "disc");
        cyc(1, 0, 0, 0, 0, 0, O_DISCBR, "disc_br");
        cyc(0, 1, 0, 0, 0, 0, O_DISC,   "disc_drop");
        cyc(0, 1, 0, 0, 0, 0, O_NORM,   "after_disc");
        chk_cnt("cnt_seq");

        // Asynchronous reset in the middle of a wait
        cyc(0, 0, 0, 0, 0, 0, O_MISS, "wait_pre_rst");
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1; m_reset = 1'b1;
        #1;
        chk("rst_mid", w_out, O_BOOT);
        model_update();
        chk_cnt("rst_mid_cnt");
        tick();
        tick();
        reset = 1'b0; m_reset = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, O_BOOT, "reboot0");
        cyc(0, 1, 0, 0, 0, 0, O_BOOT, "reboot1");
        cyc(0, 1, 0, 0, 0, 0, O_NORM, "reboot_run");

        // Random run against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1; m_reset = 1'b1;
                tick();
                reset = 1'b0; m_reset = 1'b0;
            end
            drive(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 70),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            #1;
            chk("rand", w_out, model_out());
            chk("rand_stall_and_flush", {4'b0, StallD & FlushD}, 5'b0);
            if ((i % 100) == 0) chk_cnt("rand_cnt");
            tick();
        end
        chk_cnt("final_cnt");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
